wb_cmd_master: RTL and testbench
================================

# wb_cmd_master

Wishbone B4 pipelined initiator that turns single read/write commands from an internal valid/ready port into one Wishbone transaction each, returning read data and a status code. Sits between local control logic (sequencers, DMA-lite, bring-up FSMs) and generated register-bank slaves on the same clock. It handles `stall`, `ack`, `err` and `rty`, applies a bounded retry, and enforces a timeout so a dead slave cannot hang the bus.

## Interface
- `ADDR_WIDTH`, 32: width of `cmd_adr_i` and `wb_adr_o` (byte address).
- `TIMEOUT`, 255: cycles allowed from strobe issue to termination; range 1..65535.
- `RETRY_MAX`, 3: number of re-issues after `rty`; 0 means no retry.
- `clk_i` in 1: single clock, all logic rising-edge.
- `rst_n_i` in 1: synchronous, active-low reset.
- `cmd_valid_i` in 1: command present.
- `cmd_ready_o` out 1: command accepted when `cmd_valid_i` and `cmd_ready_o` are both high.
- `cmd_we_i` in 1: 1 = write, 0 = read.
- `cmd_adr_i` in ADDR_WIDTH: byte address.
- `cmd_sel_i` in 4: byte enables.
- `cmd_dat_i` in 32: write data.
- `rsp_valid_o` out 1: response present.
- `rsp_ready_i` in 1: response consumed when `rsp_valid_o` and `rsp_ready_i` are both high.
- `rsp_dat_o` out 32: read data; 0 for writes and for failed reads.
- `rsp_status_o` out 2: 0 OK, 1 ERR, 2 RTY_EXHAUSTED, 3 TIMEOUT.
- `wb_cyc_o`, `wb_stb_o`, `wb_we_o` out 1 each: Wishbone master controls.
- `wb_adr_o` out ADDR_WIDTH; `wb_sel_o` out 4; `wb_dat_o` out 32.
- `wb_ack_i`, `wb_err_i`, `wb_rty_i`, `wb_stall_i` in 1 each; `wb_dat_i` in 32.

## Operation
- The FSM has four states: IDLE, STROBE, WAIT, RESP.
- **IDLE:** `cmd_ready_o` = 1. On handshake, latch `we`/`adr`/`sel`/`dat`, clear the retry and timeout counters, and go to STROBE.
- **STROBE:** `cyc` = 1 and `stb` = 1.
  - If `stall` = 0, the strobe is accepted and the state goes to WAIT. A termination seen in the same cycle is not evaluated here.
  - If `stall` = 1, hold `stb` and all outputs stable.
- **WAIT:** `cyc` = 1 and `stb` = 0. Terminations are prioritised err > rty > ack.
  - `err`: status ERR, go to RESP.
  - `ack`: status OK; capture `wb_dat_i` into `rsp_dat_o` if reading; go to RESP.
  - `rty` with retry count < RETRY_MAX: increment the retry count, reload the timeout, return to STROBE. `cyc` stays high across the retry.
  - `rty` with retry count = RETRY_MAX: status RTY_EXHAUSTED, go to RESP.
- **Timeout:** the counter runs in STROBE and WAIT. On reaching TIMEOUT with no termination in that cycle, set status TIMEOUT and go to RESP. A termination arriving in the expiry cycle wins over the timeout.
- **RESP:** `cyc` = 0 and `rsp_valid_o` = 1. Data and status are held stable until `rsp_ready_i`, then the state returns to IDLE.
- Exactly one outstanding transaction; no command is accepted while not in IDLE.
- Terminations outside STROBE and WAIT are ignored.
- `wb_adr_o`, `wb_sel_o`, `wb_we_o`, `wb_dat_o` are registered from the latched command and constant for the whole transaction, retries included.

## Timing
- **Reset values:** state IDLE; `cmd_ready_o` = 1 once reset deasserts. All of the following are 0: `wb_cyc_o`, `wb_stb_o`, `wb_we_o`, `wb_adr_o`, `wb_sel_o`, `wb_dat_o`, `rsp_valid_o`, `rsp_dat_o`, `rsp_status_o`.
- Reset asserted mid-transaction drops `cyc`/`stb` on the next edge; the pending response is discarded.
- **Command to bus:** handshake on edge N gives `cyc`/`stb` high from N+1.
- **Stall:** each `stall` cycle extends STROBE by one cycle.
- **Termination to response:** termination sampled at edge M gives `rsp_valid_o` high and `cyc` low from M+1.
- **Minimum read** (no stall, slave ack 2 cycles after strobe): command edge 0, `stb` cycle 1, ack at edge 3, `rsp_valid_o` from cycle 4.
- **Back-to-back:** if `rsp_ready_i` is high on the first RESP cycle, `cmd_ready_o` is high the next cycle. Throughput is one command per (bus latency + 3) cycles.
- **Timeout width:** the counter is 16 bits and saturates; it never wraps.

## Structure
- Package `wb_master_pkg` holds:
  - the status constants `WBM_OK`, `WBM_ERR`, `WBM_RTY`, `WBM_TIMEOUT`;
  - the state enum;
  - the Wishbone master-out and master-in record/struct types shared with other initiators.
- Single module, no sub-module. Timeout and retry counters are inline.

## Test plan
- **Write OK:** write `adr` = 0x4, `dat` = 0x00000013, `sel` = 0xF against the register-bank slave (ack 2 cycles after strobe) → one strobe cycle, status 0; a read of 0x4 then returns 0x00000013.
- **Stall:** read 0x0 with `stall` held high for 3 cycles → `stb` stays high for 4 cycles with `adr` stable; response status 0 with the correct data.
- **Retry:** slave answers `rty` twice then `ack` with RETRY_MAX = 3 → 3 strobes and `cyc` never drops; status 0. With 4 `rty` answers → status 2 and `rsp_dat_o` = 0.
- **Timeout:** TIMEOUT = 8 and the slave never responds → `rsp_valid_o` rises 9 cycles after strobe issue with status 3. A second case with `ack` arriving exactly in the expiry cycle → status 0.
- **Priority:** `err` and `ack` asserted together in WAIT → status 1.
- **Backpressure and reset:** `rsp_ready_i` held low for 5 cycles → response stable and `cmd_ready_o` low. Reset asserted during WAIT → `cyc` low next cycle and `rsp_valid_o` stays 0.

Source files
------------

// File: rtl/wb_master_pkg.sv
// Shared definitions for Wishbone B4 pipelined initiators.
// Contents:
//   - response status codes returned on rsp_status_o
//   - command-master FSM state encoding
//   - master-out / master-in record types for bus fabric code
package wb_master_pkg;

  localparam logic [1:0] WBM_OK      = 2'd0;
  localparam logic [1:0] WBM_ERR     = 2'd1;
  localparam logic [1:0] WBM_RTY     = 2'd2;
  localparam logic [1:0] WBM_TIMEOUT = 2'd3;

  localparam int WB_ADR_W = 32;
  localparam int WB_DAT_W = 32;
  localparam int WB_SEL_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_STROBE = 2'd1,
    ST_WAIT   = 2'd2,
    ST_RESP   = 2'd3
  } wbm_state_e;

  typedef struct packed {
    logic                cyc;
    logic                stb;
    logic                we;
    logic [WB_ADR_W-1:0] adr;
    logic [WB_SEL_W-1:0] sel;
    logic [WB_DAT_W-1:0] dat;
  } wb_m2s_t;

  typedef struct packed {
    logic                ack;
    logic                err;
    logic                rty;
    logic                stall;
    logic [WB_DAT_W-1:0] dat;
  } wb_s2m_t;

endpackage

// File: rtl/wb_cmd_master.sv
// Wishbone B4 pipelined command master.
// Turns one valid/ready command into one Wishbone transaction and returns
// read data plus a status code (OK / ERR / RTY exhausted / TIMEOUT).
// Ports:
//   clk_i, rst_n_i                      clock, synchronous active-low reset
//   cmd_valid_i/cmd_ready_o             command handshake
//   cmd_we_i, cmd_adr_i, cmd_sel_i, cmd_dat_i   command payload
//   rsp_valid_o/rsp_ready_i             response handshake
//   rsp_dat_o, rsp_status_o             read data, status
//   wb_cyc_o, wb_stb_o, wb_we_o, wb_adr_o, wb_sel_o, wb_dat_o   bus out
//   wb_ack_i, wb_err_i, wb_rty_i, wb_stall_i, wb_dat_i          bus in
//
// state  | meaning
// IDLE   | cmd_ready_o high, waiting for a command
// STROBE | cyc+stb driven, waiting for stall low
// WAIT   | cyc only, waiting for ack/err/rty or timeout
// RESP   | rsp_valid_o high, waiting for rsp_ready_i
module wb_cmd_master
  import wb_master_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int TIMEOUT    = 255,
  parameter int RETRY_MAX  = 3
) (
  input  logic                  clk_i,
  input  logic                  rst_n_i,
  input  logic                  cmd_valid_i,
  output logic                  cmd_ready_o,
  input  logic                  cmd_we_i,
  input  logic [ADDR_WIDTH-1:0] cmd_adr_i,
  input  logic [3:0]            cmd_sel_i,
  input  logic [31:0]           cmd_dat_i,
  output logic                  rsp_valid_o,
  input  logic                  rsp_ready_i,
  output logic [31:0]           rsp_dat_o,
  output logic [1:0]            rsp_status_o,
  output logic                  wb_cyc_o,
  output logic                  wb_stb_o,
  output logic                  wb_we_o,
  output logic [ADDR_WIDTH-1:0] wb_adr_o,
  output logic [3:0]            wb_sel_o,
  output logic [31:0]           wb_dat_o,
  input  logic                  wb_ack_i,
  input  logic                  wb_err_i,
  input  logic                  wb_rty_i,
  input  logic                  wb_stall_i,
  input  logic [31:0]           wb_dat_i
);

  localparam int                RCNT_W    = (RETRY_MAX < 1) ? 1 : $clog2(RETRY_MAX + 1);
  localparam logic [RCNT_W-1:0] RETRY_LIM = RCNT_W'(RETRY_MAX);
  localparam logic [15:0]       TMO_LOAD  = 16'(TIMEOUT);

  wbm_state_e        state;
  wbm_state_e        state_nxt;
  wb_s2m_t           s2m;
  logic [RCNT_W-1:0] retry_cnt;
  logic [15:0]       tmo_cnt;
  logic              tmo_expired;
  logic              cmd_take;
  logic              rsp_load;
  logic              rsp_capture;
  logic              retry_go;
  logic [1:0]        status_nxt;

  assign s2m = '{ack: wb_ack_i, err: wb_err_i, rty: wb_rty_i,
                 stall: wb_stall_i, dat: wb_dat_i};

  // Down-counter loaded with TIMEOUT; terminal count 0 means expired.
  // It stops at 0, so it can never wrap back into a live value.
  assign tmo_expired = (tmo_cnt == 16'd0);
  assign cmd_take    = (state == ST_IDLE) && cmd_valid_i;

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    status_nxt  = WBM_OK;
    rsp_load    = 1'b0;
    rsp_capture = 1'b0;
    retry_go    = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (cmd_valid_i) state_nxt = ST_STROBE;
      end
      ST_STROBE: begin
        // terminations are not looked at until the strobe has been accepted
        if (tmo_expired) begin
          state_nxt  = ST_RESP;
          rsp_load   = 1'b1;
          status_nxt = WBM_TIMEOUT;
        end else if (!s2m.stall) begin
          state_nxt = ST_WAIT;
        end
      end
      ST_WAIT: begin
        state_nxt = ST_RESP;
        rsp_load  = 1'b1;
        if (s2m.err) begin
          status_nxt = WBM_ERR;
        end else if (s2m.rty) begin
          if (retry_cnt < RETRY_LIM) begin
            state_nxt = ST_STROBE;
            rsp_load  = 1'b0;
            retry_go  = 1'b1;
          end else begin
            status_nxt = WBM_RTY;
          end
        end else if (s2m.ack) begin
          status_nxt  = WBM_OK;
          rsp_capture = !wb_we_o;
        end else if (tmo_expired) begin
          status_nxt = WBM_TIMEOUT;
        end else begin
          state_nxt = ST_WAIT;
          rsp_load  = 1'b0;
        end
      end
      ST_RESP: begin
        if (rsp_ready_i) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    cmd_ready_o = 1'b0;
    wb_cyc_o    = 1'b0;
    wb_stb_o    = 1'b0;
    rsp_valid_o = 1'b0;
    unique case (state)
      ST_IDLE:   cmd_ready_o = 1'b1;
      ST_STROBE: begin
        wb_cyc_o = 1'b1;
        wb_stb_o = 1'b1;
      end
      ST_WAIT:   wb_cyc_o    = 1'b1;
      ST_RESP:   rsp_valid_o = 1'b1;
      default:   cmd_ready_o = 1'b0;
    endcase
  end

  // Bus payload registers double as the command latch, so they stay
  // constant across stalls and retries.
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      wb_we_o      <= 1'b0;
      wb_adr_o     <= '0;
      wb_sel_o     <= '0;
      wb_dat_o     <= '0;
      rsp_dat_o    <= '0;
      rsp_status_o <= WBM_OK;
      retry_cnt    <= '0;
      tmo_cnt      <= '0;
    end else begin
      if (cmd_take) begin
        wb_we_o      <= cmd_we_i;
        wb_adr_o     <= cmd_adr_i;
        wb_sel_o     <= cmd_sel_i;
        wb_dat_o     <= cmd_dat_i;
        rsp_dat_o    <= '0;
        rsp_status_o <= WBM_OK;
        retry_cnt    <= '0;
        tmo_cnt      <= TMO_LOAD;
      end else if (retry_go) begin
        retry_cnt <= retry_cnt + 1'b1;
        tmo_cnt   <= TMO_LOAD;
      end else if ((state == ST_STROBE || state == ST_WAIT) && !tmo_expired) begin
        tmo_cnt <= tmo_cnt - 1'b1;
      end
      if (rsp_load) begin
        rsp_status_o <= status_nxt;
        if (rsp_capture) rsp_dat_o <= s2m.dat;
      end
    end
  end

endmodule

// File: tb/tb_wb_cmd_master.sv
// Bench for wb_cmd_master: a behavioural register-bank slave with
// programmable stall / latency / retry / termination kind, a table of
// directed vectors, and hand sequences for backpressure and mid-cycle reset.
module tb_wb_cmd_master;

  localparam int K_ACK    = 0;
  localparam int K_ERR    = 1;
  localparam int K_NONE   = 2;
  localparam int K_ERRACK = 3;

  logic        clk;
  logic        rst_n;
  logic        cmd_valid, cmd_ready, cmd_we;
  logic [31:0] cmd_adr;
  logic [3:0]  cmd_sel;
  logic [31:0] cmd_dat;
  logic        rsp_valid, rsp_ready;
  logic [31:0] rsp_dat;
  logic [1:0]  rsp_status;
  logic        wb_cyc, wb_stb, wb_we;
  logic [31:0] wb_adr;
  logic [3:0]  wb_sel;
  logic [31:0] wb_dat_m;
  logic        wb_ack, wb_err, wb_rty, wb_stall;
  logic [31:0] wb_dat_s;

  wb_cmd_master #(.ADDR_WIDTH(32), .TIMEOUT(8), .RETRY_MAX(3)) dut (
    .clk_i(clk), .rst_n_i(rst_n),
    .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready), .cmd_we_i(cmd_we),
    .cmd_adr_i(cmd_adr), .cmd_sel_i(cmd_sel), .cmd_dat_i(cmd_dat),
    .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready),
    .rsp_dat_o(rsp_dat), .rsp_status_o(rsp_status),
    .wb_cyc_o(wb_cyc), .wb_stb_o(wb_stb), .wb_we_o(wb_we),
    .wb_adr_o(wb_adr), .wb_sel_o(wb_sel), .wb_dat_o(wb_dat_m),
    .wb_ack_i(wb_ack), .wb_err_i(wb_err), .wb_rty_i(wb_rty),
    .wb_stall_i(wb_stall), .wb_dat_i(wb_dat_s)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- slave model ----------------
  int          cfg_stall, cfg_dly, cfg_rty, cfg_kind;
  logic [31:0] mem [16];
  bit          mem_ready = 1'b0;
  bit          active = 1'b0, pending = 1'b0, first_acc = 1'b0;
  int          stall_left, rty_left, cnt;
  logic [31:0] cap_adr, cap_dat;
  logic        cap_we;
  logic [3:0]  cap_sel;

  initial begin
    wb_ack = 1'b0; wb_err = 1'b0; wb_rty = 1'b0; wb_stall = 1'b0;
    wb_dat_s = 32'hDEAD_BEEF;
  end

  always @(negedge clk) begin
    logic [31:0] m;
    logic [3:0]  idx;
    if (!mem_ready) begin
      for (int i = 0; i < 16; i++) mem[i] = 32'hC0DE_0000 + 32'(i);
      mem_ready = 1'b1;
    end
    wb_ack = 1'b0; wb_err = 1'b0; wb_rty = 1'b0; wb_stall = 1'b0;
    wb_dat_s = 32'hDEAD_BEEF;
    if (!wb_cyc) begin
      active  = 1'b0;
      pending = 1'b0;
    end else begin
      if (!active) begin
        active     = 1'b1;
        first_acc  = 1'b1;
        pending    = 1'b0;
        stall_left = cfg_stall;
        rty_left   = cfg_rty;
      end
      if (wb_stb) begin
        if (stall_left > 0) begin
          wb_stall   = 1'b1;
          stall_left = stall_left - 1;
        end else begin
          pending = 1'b1;
          cnt     = cfg_dly;
          if (first_acc) begin
            cap_adr = wb_adr; cap_we = wb_we; cap_sel = wb_sel; cap_dat = wb_dat_m;
            first_acc = 1'b0;
          end
        end
      end else if (pending) begin
        cnt = cnt - 1;
        if (cnt <= 0) begin
          pending = 1'b0;
          if (rty_left > 0) begin
            wb_rty   = 1'b1;
            rty_left = rty_left - 1;
          end else begin
            case (cfg_kind)
              K_ACK: begin
                wb_ack = 1'b1;
                idx    = wb_adr[5:2];
                m      = {{8{wb_sel[3]}}, {8{wb_sel[2]}}, {8{wb_sel[1]}}, {8{wb_sel[0]}}};
                if (wb_we) mem[idx] = (mem[idx] & ~m) | (wb_dat_m & m);
                else       wb_dat_s = mem[idx];
              end
              K_ERR:    wb_err = 1'b1;
              K_ERRACK: begin wb_err = 1'b1; wb_ack = 1'b1; end
              default:  ;
            endcase
          end
        end
      end
    end
  end

  // ---------------- checking ----------------
  int n_vec = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  typedef struct {
    logic        we;
    logic [31:0] adr;
    logic [3:0]  sel;
    logic [31:0] dat;
    int          stall, dly, rty, kind;
    logic [1:0]  e_status;
    logic [31:0] e_dat;
    int          e_lat, e_stb;
  } vec_t;

  vec_t vecs[14];

  function automatic vec_t mk(logic we, logic [31:0] adr, logic [3:0] sel, logic [31:0] dat,
                              int stall, int dly, int rty, int kind,
                              logic [1:0] es, logic [31:0] ed, int el, int eb);
    vec_t v;
    v.we = we; v.adr = adr; v.sel = sel; v.dat = dat;
    v.stall = stall; v.dly = dly; v.rty = rty; v.kind = kind;
    v.e_status = es; v.e_dat = ed; v.e_lat = el; v.e_stb = eb;
    return v;
  endfunction

  // Issues one command and checks it; lat counts cycles from the handshake
  // edge to the first cycle with rsp_valid high.
  task automatic run_cmd(input int id, input vec_t v);
    int lat, stbs, cyc_gap, adr_bad, w;
    logic [31:0] got_dat;
    logic [1:0]  got_st;
    for (w = 0; w < 20 && !cmd_ready; w++) @(negedge clk);
    if (!cmd_ready) begin
      n_vec++; n_bad++;
      $display("FAIL v%0d_cmd_ready: not ready within 20 cycles", id);
    end
    cfg_stall = v.stall; cfg_dly = v.dly; cfg_rty = v.rty; cfg_kind = v.kind;
    cmd_valid = 1'b1; cmd_we = v.we; cmd_adr = v.adr; cmd_sel = v.sel; cmd_dat = v.dat;
    @(negedge clk);
    cmd_valid = 1'b0;
    lat = -1; stbs = 0; cyc_gap = 0; adr_bad = 0;
    got_dat = '0; got_st = '0;
    for (int c = 1; c <= 60; c++) begin
      if (rsp_valid) begin
        lat = c; got_dat = rsp_dat; got_st = rsp_status;
        break;
      end
      if (wb_stb) stbs++;
      if (!wb_cyc) cyc_gap++;
      if (wb_adr !== v.adr) adr_bad++;
      @(negedge clk);
    end
    chk($sformatf("v%0d_status", id), 32'(got_st), 32'(v.e_status));
    chk($sformatf("v%0d_rdat", id), got_dat, v.e_dat);
    chk($sformatf("v%0d_latency", id), 32'(lat), 32'(v.e_lat));
    chk($sformatf("v%0d_stb_cycles", id), 32'(stbs), 32'(v.e_stb));
    chk($sformatf("v%0d_cyc_drops", id), 32'(cyc_gap), 32'd0);
    chk($sformatf("v%0d_adr_unstable", id), 32'(adr_bad), 32'd0);
    chk($sformatf("v%0d_bus_adr", id), cap_adr, v.adr);
    chk($sformatf("v%0d_bus_we_sel", id), {27'd0, cap_we, cap_sel}, {27'd0, v.we, v.sel});
    chk($sformatf("v%0d_bus_wdat", id), cap_dat, v.dat);
    @(negedge clk);
    chk($sformatf("v%0d_back_to_back", id), {30'd0, cmd_ready, rsp_valid}, 32'd2);
  endtask

  initial begin
    int bad, vcount;
    rst_n = 1'b0; cmd_valid = 1'b0; cmd_we = 1'b0; cmd_adr = '0; cmd_sel = '0; cmd_dat = '0;
    rsp_ready = 1'b1;
    cfg_stall = 0; cfg_dly = 2; cfg_rty = 0; cfg_kind = K_ACK;

    //         we    adr           sel   dat            st dly rty kind      status rdat          lat stb
    vecs[0]  = mk(1'b1, 32'h04, 4'hF, 32'h0000_0013, 0, 2, 0, K_ACK,    2'd0, 32'h0,         4,  1);
    vecs[1]  = mk(1'b0, 32'h04, 4'hF, 32'hFFFF_0001, 0, 2, 0, K_ACK,    2'd0, 32'h0000_0013, 4,  1);
    vecs[2]  = mk(1'b0, 32'h00, 4'hF, 32'hFFFF_0002, 3, 2, 0, K_ACK,    2'd0, 32'hC0DE_0000, 7,  4);
    vecs[3]  = mk(1'b0, 32'h08, 4'hF, 32'hFFFF_0003, 0, 2, 2, K_ACK,    2'd0, 32'hC0DE_0002, 10, 3);
    vecs[4]  = mk(1'b0, 32'h08, 4'hF, 32'hFFFF_0004, 0, 2, 4, K_ACK,    2'd2, 32'h0,         13, 4);
    vecs[5]  = mk(1'b0, 32'h08, 4'hF, 32'hFFFF_0005, 0, 2, 3, K_ACK,    2'd0, 32'hC0DE_0002, 13, 4);
    vecs[6]  = mk(1'b0, 32'h0C, 4'hF, 32'hFFFF_0006, 0, 2, 0, K_NONE,   2'd3, 32'h0,         10, 1);
    vecs[7]  = mk(1'b0, 32'h0C, 4'hF, 32'hFFFF_0007, 0, 7, 0, K_ACK,    2'd0, 32'hC0DE_0003, 9,  1);
    vecs[8]  = mk(1'b0, 32'h0C, 4'hF, 32'hFFFF_0008, 0, 8, 0, K_ACK,    2'd0, 32'hC0DE_0003, 10, 1);
    vecs[9]  = mk(1'b0, 32'h0C, 4'hF, 32'hFFFF_0009, 0, 9, 0, K_ACK,    2'd3, 32'h0,         10, 1);
    vecs[10] = mk(1'b0, 32'h10, 4'hF, 32'hFFFF_000A, 0, 2, 0, K_ERRACK, 2'd1, 32'h0,         4,  1);
    vecs[11] = mk(1'b1, 32'h14, 4'hF, 32'h1234_5678, 0, 1, 0, K_ERR,    2'd1, 32'h0,         3,  1);
    vecs[12] = mk(1'b1, 32'h18, 4'h3, 32'hA5A5_5A5A, 0, 1, 0, K_ACK,    2'd0, 32'h0,         3,  1);
    vecs[13] = mk(1'b0, 32'h18, 4'hF, 32'hFFFF_000D, 0, 1, 0, K_ACK,    2'd0, 32'hC0DE_5A5A, 3,  1);

    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("reset_cmd_ready", {31'd0, cmd_ready}, 32'd1);
    chk("reset_ctrl", {27'd0, wb_cyc, wb_stb, wb_we, rsp_valid, 1'b0} | {30'd0, rsp_status}, 32'd0);
    chk("reset_wb_adr", wb_adr, 32'd0);
    chk("reset_wb_sel", {28'd0, wb_sel}, 32'd0);
    chk("reset_wb_dat", wb_dat_m, 32'd0);
    chk("reset_rsp_dat", rsp_dat, 32'd0);

    for (int i = 0; i < 14; i++) run_cmd(i, vecs[i]);

    // response backpressure: rsp_ready low for 5 RESP cycles
    rsp_ready = 1'b0;
    cfg_stall = 0; cfg_dly = 2; cfg_rty = 0; cfg_kind = K_ACK;
    @(negedge clk);
    cmd_valid = 1'b1; cmd_we = 1'b0; cmd_adr = 32'h04; cmd_sel = 4'hF; cmd_dat = '0;
    @(negedge clk);
    cmd_valid = 1'b0;
    for (int c = 0; c < 40 && !rsp_valid; c++) @(negedge clk);
    bad = 0;
    for (int c = 0; c < 5; c++) begin
      if (!(rsp_valid && rsp_dat == 32'h0000_0013 && rsp_status == 2'd0 && !cmd_ready)) bad++;
      @(negedge clk);
    end
    chk("bp_hold_cycles_bad", 32'(bad), 32'd0);
    chk("bp_still_valid", {31'd0, rsp_valid}, 32'd1);
    rsp_ready = 1'b1;
    @(negedge clk);
    chk("bp_release", {30'd0, cmd_ready, rsp_valid}, 32'd2);

    // reset during WAIT against a silent slave
    cfg_kind = K_NONE;
    cmd_valid = 1'b1; cmd_we = 1'b0; cmd_adr = 32'h1C; cmd_sel = 4'hF;
    @(negedge clk);
    cmd_valid = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_pre_cyc_stb", {30'd0, wb_cyc, wb_stb}, 32'd2);
    rst_n = 1'b0;
    @(negedge clk);
    chk("rst_cyc_stb_drop", {30'd0, wb_cyc, wb_stb}, 32'd0);
    rst_n = 1'b1;
    vcount = 0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (rsp_valid) vcount++;
    end
    chk("rst_no_response", 32'(vcount), 32'd0);
    chk("rst_idle_ready", {31'd0, cmd_ready}, 32'd1);
    chk("rst_adr_cleared", wb_adr, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
